// File: rtl/hazard_unit_if.sv
// Hazard unit port bundle: decoded register fields and control bits from the
// D/E/M/W stages plus cache handshakes in, stall/flush/forward controls out.
interface hazard_unit_if;
    logic [4:0] rs_d_i;
    logic [4:0] rt_d_i;
    logic       branch_d_i;
    logic       pc_src_d_i;
    logic [4:0] rs_e_i;
    logic [4:0] rt_e_i;
    logic [4:0] write_reg_e_i;
    logic       reg_write_e_i;
    logic       mem_to_reg_e_i;
    logic [4:0] write_reg_m_i;
    logic       reg_write_m_i;
    logic       mem_to_reg_m_i;
    logic [4:0] write_reg_w_i;
    logic       reg_write_w_i;
    logic       md_start_e_i;
    logic       icache_miss_i;
    logic       icache_ready_i;
    logic       dcache_miss_i;
    logic       dcache_ready_i;
    logic       stall_f_o;
    logic       stall_d_o;
    logic       stall_e_o;
    logic       stall_m_o;
    logic       stall_w_o;
    logic       flush_d_o;
    logic       flush_e_o;
    logic       flush_m_o;
    logic       forward_a_d_o;
    logic       forward_b_d_o;
    logic [1:0] forward_a_e_o;
    logic [1:0] forward_b_e_o;
    logic       md_busy_o;

    // Hazard unit side
    modport slave (
        input  rs_d_i, rt_d_i, branch_d_i, pc_src_d_i,
        input  rs_e_i, rt_e_i, write_reg_e_i, reg_write_e_i, mem_to_reg_e_i,
        input  write_reg_m_i, reg_write_m_i, mem_to_reg_m_i,
        input  write_reg_w_i, reg_write_w_i, md_start_e_i,
        input  icache_miss_i, icache_ready_i, dcache_miss_i, dcache_ready_i,
        output stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
        output flush_d_o, flush_e_o, flush_m_o,
        output forward_a_d_o, forward_b_d_o, forward_a_e_o, forward_b_e_o,
        output md_busy_o
    );

    // Datapath side
    modport master (
        output rs_d_i, rt_d_i, branch_d_i, pc_src_d_i,
        output rs_e_i, rt_e_i, write_reg_e_i, reg_write_e_i, mem_to_reg_e_i,
        output write_reg_m_i, reg_write_m_i, mem_to_reg_m_i,
        output write_reg_w_i, reg_write_w_i, md_start_e_i,
        output icache_miss_i, icache_ready_i, dcache_miss_i, dcache_ready_i,
        input  stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o,
        input  flush_d_o, flush_e_o, flush_m_o,
        input  forward_a_d_o, forward_b_d_o, forward_a_e_o, forward_b_e_o,
        input  md_busy_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and branch-compare
// bubbles, cache-miss wait sequencing and multi-cycle mult/div hold.
module hazard_unit #(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    hazard_unit_if.slave   hz
);
    localparam int unsigned CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_WAIT = 2'd1,
        ST_I_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_md_cnt;

    logic             w_lw_stall;
    logic             w_br_stall;
    logic             w_md_busy;
    logic             w_d_hold;
    logic             w_i_hold;
    logic [4:0]       w_stall;   // {f, d, e, m, w}
    logic [2:0]       w_flush;   // {d, e, m}
    logic [1:0]       w_fwd_a_e;
    logic [1:0]       w_fwd_b_e;
    logic             w_fwd_a_d;
    logic             w_fwd_b_d;
    logic             w_md_busy_out;

    // Cache-wait FSM and mult/div occupancy counter; both drop their work on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_md_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The D-side miss belongs to the older instruction, so it wins
                    if (hz.dcache_miss_i) begin
                        r_state <= ST_D_WAIT;
                    end else if (hz.icache_miss_i) begin
                        r_state <= ST_I_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_D_WAIT: begin
                    if (hz.dcache_ready_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_D_WAIT;
                    end
                end
                ST_I_WAIT: begin
                    if (hz.icache_ready_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_I_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // The unit's progress is frozen while the whole pipe waits on the D-side
            if (r_state != ST_D_WAIT) begin
                if (r_md_cnt != {CNT_W{1'b0}}) begin
                    r_md_cnt <= r_md_cnt - CNT_W'(1);
                end else if (hz.md_start_e_i) begin
                    r_md_cnt <= CNT_W'(MD_LATENCY - 1);
                end else begin
                    r_md_cnt <= r_md_cnt;
                end
            end else begin
                r_md_cnt <= r_md_cnt;
            end
        end
    end

    // Hazard detection terms; register 0 is hardwired so it never forms a branch dependency
    always_comb begin
        w_lw_stall = hz.mem_to_reg_e_i &&
                     ((hz.rt_e_i == hz.rs_d_i) || (hz.rt_e_i == hz.rt_d_i));
        w_br_stall = hz.branch_d_i && (
            (hz.reg_write_e_i && (hz.write_reg_e_i != 5'd0) &&
             ((hz.write_reg_e_i == hz.rs_d_i) || (hz.write_reg_e_i == hz.rt_d_i))) ||
            (hz.mem_to_reg_m_i && (hz.write_reg_m_i != 5'd0) &&
             ((hz.write_reg_m_i == hz.rs_d_i) || (hz.write_reg_m_i == hz.rt_d_i))));
        w_md_busy  = (r_md_cnt != {CNT_W{1'b0}}) ||
                     (hz.md_start_e_i && (r_md_cnt == {CNT_W{1'b0}}));
        w_d_hold   = (r_state == ST_D_WAIT) || ((r_state == ST_IDLE) && hz.dcache_miss_i);
        w_i_hold   = (r_state == ST_I_WAIT) || ((r_state == ST_IDLE) && hz.icache_miss_i);
    end

    // Forwarding selects; the M result is younger than W so it takes precedence
    always_comb begin
        w_fwd_a_e = 2'b00;
        w_fwd_b_e = 2'b00;
        w_fwd_a_d = 1'b0;
        w_fwd_b_d = 1'b0;
        if (rst_i) begin
            w_fwd_a_e = 2'b00;
            w_fwd_b_e = 2'b00;
        end else begin
            if ((hz.rs_e_i != 5'd0) && hz.reg_write_m_i && (hz.write_reg_m_i == hz.rs_e_i)) begin
                w_fwd_a_e = 2'b10;
            end else if ((hz.rs_e_i != 5'd0) && hz.reg_write_w_i && (hz.write_reg_w_i == hz.rs_e_i)) begin
                w_fwd_a_e = 2'b01;
            end else begin
                w_fwd_a_e = 2'b00;
            end
            if ((hz.rt_e_i != 5'd0) && hz.reg_write_m_i && (hz.write_reg_m_i == hz.rt_e_i)) begin
                w_fwd_b_e = 2'b10;
            end else if ((hz.rt_e_i != 5'd0) && hz.reg_write_w_i && (hz.write_reg_w_i == hz.rt_e_i)) begin
                w_fwd_b_e = 2'b01;
            end else begin
                w_fwd_b_e = 2'b00;
            end
            w_fwd_a_d = (hz.rs_d_i != 5'd0) && hz.reg_write_m_i && (hz.write_reg_m_i == hz.rs_d_i);
            w_fwd_b_d = (hz.rt_d_i != 5'd0) && hz.reg_write_m_i && (hz.write_reg_m_i == hz.rt_d_i);
        end
    end

    // Prioritised stall/flush selection; a stage is never both held and bubbled
    always_comb begin
        w_stall       = 5'b00000;
        w_flush       = 3'b000;
        w_md_busy_out = 1'b0;
        if (rst_i) begin
            w_stall       = 5'b00000;
            w_flush       = 3'b000;
            w_md_busy_out = 1'b0;
        end else begin
            w_md_busy_out = w_md_busy;
            if (w_d_hold) begin
                w_stall = 5'b11111;
            end else if (w_md_busy) begin
                w_stall = 5'b11100;
                w_flush = 3'b001;
            end else if (w_lw_stall || w_br_stall) begin
                w_stall = 5'b11000;
                w_flush = 3'b010;
            end else if (w_i_hold) begin
                w_stall = 5'b10000;
                w_flush = 3'b100;
            end else if (hz.pc_src_d_i) begin
                w_flush = 3'b100;
            end else begin
                w_stall = 5'b00000;
                w_flush = 3'b000;
            end
        end
    end

    assign hz.stall_f_o     = w_stall[4];
    assign hz.stall_d_o     = w_stall[3];
    assign hz.stall_e_o     = w_stall[2];
    assign hz.stall_m_o     = w_stall[1];
    assign hz.stall_w_o     = w_stall[0];
    assign hz.flush_d_o     = w_flush[2];
    assign hz.flush_e_o     = w_flush[1];
    assign hz.flush_m_o     = w_flush[0];
    assign hz.forward_a_e_o = w_fwd_a_e;
    assign hz.forward_b_e_o = w_fwd_b_e;
    assign hz.forward_a_d_o = w_fwd_a_d;
    assign hz.forward_b_d_o = w_fwd_b_d;
    assign hz.md_busy_o     = w_md_busy_out;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MD_LATENCY = 4.
module tb_hazard_unit;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hazard_unit_if hz ();

    hazard_unit #(.MD_LATENCY(4)) u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (hz)
    );

    always #5 clk_i = ~clk_i;

    // Compare one packed observation against its hand-computed value
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {stall f,d,e,m,w, flush d,e,m}
    function automatic logic [7:0] sf();
        return {hz.stall_f_o, hz.stall_d_o, hz.stall_e_o, hz.stall_m_o, hz.stall_w_o,
                hz.flush_d_o, hz.flush_e_o, hz.flush_m_o};
    endfunction

    // {2'b0, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}
    function automatic logic [7:0] fw();
        return {2'b00, hz.forward_a_e_o, hz.forward_b_e_o, hz.forward_a_d_o, hz.forward_b_d_o};
    endfunction

    function automatic logic [7:0] busy();
        return {7'd0, hz.md_busy_o};
    endfunction

    task automatic clr();
        hz.rs_d_i = 5'd0; hz.rt_d_i = 5'd0; hz.branch_d_i = 1'b0; hz.pc_src_d_i = 1'b0;
        hz.rs_e_i = 5'd0; hz.rt_e_i = 5'd0; hz.write_reg_e_i = 5'd0;
        hz.reg_write_e_i = 1'b0; hz.mem_to_reg_e_i = 1'b0;
        hz.write_reg_m_i = 5'd0; hz.reg_write_m_i = 1'b0; hz.mem_to_reg_m_i = 1'b0;
        hz.write_reg_w_i = 5'd0; hz.reg_write_w_i = 1'b0; hz.md_start_e_i = 1'b0;
        hz.icache_miss_i = 1'b0; hz.icache_ready_i = 1'b0;
        hz.dcache_miss_i = 1'b0; hz.dcache_ready_i = 1'b0;
    endtask

    // Move to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset dominates even with hazards present on the inputs
        clr();
        hz.dcache_miss_i = 1'b1;
        hz.rs_e_i = 5'd5; hz.write_reg_m_i = 5'd5; hz.reg_write_m_i = 1'b1;
        hz.md_start_e_i = 1'b1;
        #2;
        chk("reset_sf", sf(), 8'h00);
        chk("reset_fw", fw(), 8'h00);
        chk("reset_busy", busy(), 8'h00);
        tick();
        clr();
        rst_i = 1'b0;
        #1;
        chk("idle_sf", sf(), 8'h00);

        // Forwarding: M beats W, W alone, register 0 never forwards
        tick();
        hz.rs_e_i = 5'd5; hz.rt_e_i = 5'd5;
        hz.write_reg_m_i = 5'd5; hz.reg_write_m_i = 1'b1;
        hz.write_reg_w_i = 5'd5; hz.reg_write_w_i = 1'b1;
        hz.rs_d_i = 5'd5;
        #1;
        chk("fwd_m_wins", fw(), 8'b00_10_10_1_0);
        hz.reg_write_m_i = 1'b0;
        #1;
        chk("fwd_w_only", fw(), 8'b00_01_01_0_0);
        hz.rs_e_i = 5'd0;
        hz.reg_write_m_i = 1'b1; hz.write_reg_m_i = 5'd0; hz.write_reg_w_i = 5'd0;
        hz.rt_e_i = 5'd0; hz.rt_d_i = 5'd0; hz.rs_d_i = 5'd0;
        #1;
        chk("fwd_r0", fw(), 8'h00);

        // Load-use: one bubble, then the load result comes from M
        tick();
        clr();
        hz.mem_to_reg_e_i = 1'b1; hz.reg_write_e_i = 1'b1; hz.write_reg_e_i = 5'd3;
        hz.rt_e_i = 5'd3; hz.rs_d_i = 5'd1; hz.rt_d_i = 5'd3;
        #1;
        chk("lw_stall", sf(), 8'b11000_010);
        tick();
        clr();
        hz.write_reg_m_i = 5'd3; hz.reg_write_m_i = 1'b1; hz.mem_to_reg_m_i = 1'b1;
        hz.rs_e_i = 5'd1; hz.rt_e_i = 5'd3;
        #1;
        chk("lw_after_sf", sf(), 8'h00);
        chk("lw_after_fw", fw(), 8'b00_00_10_0_0);

        // Branch on r4 with an ALU op writing r4 in E
        tick();
        clr();
        hz.branch_d_i = 1'b1; hz.rs_d_i = 5'd4;
        hz.reg_write_e_i = 1'b1; hz.write_reg_e_i = 5'd4;
        #1;
        chk("br_stall", sf(), 8'b11000_010);
        tick();
        clr();
        hz.branch_d_i = 1'b1; hz.rs_d_i = 5'd4; hz.pc_src_d_i = 1'b1;
        hz.reg_write_m_i = 1'b1; hz.write_reg_m_i = 5'd4;
        #1;
        chk("br_fwd_d", fw(), 8'b00_00_00_1_0);
        chk("br_taken_flush", sf(), 8'b00000_100);
        tick();
        clr();
        hz.branch_d_i = 1'b1; hz.reg_write_e_i = 1'b1;
        #1;
        chk("br_r0_nostall", sf(), 8'h00);

        // I-miss with ready in the detect cycle still waits one cycle
        tick();
        clr();
        hz.icache_miss_i = 1'b1; hz.icache_ready_i = 1'b1;
        #1;
        chk("imiss_detect", sf(), 8'b10000_100);
        tick();
        #1;
        chk("imiss_wait1", sf(), 8'b10000_100);
        tick();
        clr();
        #1;
        chk("imiss_done", sf(), 8'h00);

        // Simultaneous D and I miss: D first for 5 cycles, then I_WAIT
        tick();
        hz.dcache_miss_i = 1'b1; hz.icache_miss_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) hz.dcache_ready_i = 1'b1;
            #1;
            chk($sformatf("dmiss_c%0d", i), sf(), 8'b11111_000);
            tick();
        end
        hz.dcache_miss_i = 1'b0; hz.dcache_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) hz.icache_ready_i = 1'b1;
            #1;
            chk($sformatf("iwait_c%0d", i), sf(), 8'b10000_100);
            tick();
        end
        clr();
        #1;
        chk("miss_done", sf(), 8'h00);

        // Mult/div alone: busy exactly 4 cycles
        tick();
        hz.md_start_e_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("md_busy_c%0d", i), busy(), 8'h01);
            chk($sformatf("md_sf_c%0d", i), sf(), 8'b11100_001);
            tick();
        end
        hz.md_start_e_i = 1'b0;
        #1;
        chk("md_done_busy", busy(), 8'h00);
        chk("md_done_sf", sf(), 8'h00);

        // Mult/div with a 3-cycle D-miss in the middle: busy for 7 cycles
        tick();
        hz.md_start_e_i = 1'b1;
        #1;
        chk("mdd_c0", sf(), 8'b11100_001);
        tick();
        hz.dcache_miss_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            if (i == 4) hz.dcache_ready_i = 1'b1;
            #1;
            chk($sformatf("mdd_busy_c%0d", i), busy(), 8'h01);
            chk($sformatf("mdd_sf_c%0d", i), sf(), 8'b11111_000);
            tick();
        end
        hz.dcache_miss_i = 1'b0; hz.dcache_ready_i = 1'b0;
        for (int i = 5; i < 7; i++) begin
            #1;
            chk($sformatf("mdd_busy_c%0d", i), busy(), 8'h01);
            chk($sformatf("mdd_sf_c%0d", i), sf(), 8'b11100_001);
            tick();
        end
        hz.md_start_e_i = 1'b0;
        #1;
        chk("mdd_done", busy(), 8'h00);

        // Reset while in D_WAIT with two mult/div cycles left
        tick();
        hz.md_start_e_i = 1'b1;
        tick();
        hz.dcache_miss_i = 1'b1;
        tick();
        hz.rs_e_i = 5'd5; hz.write_reg_m_i = 5'd5; hz.reg_write_m_i = 1'b1;
        #1;
        chk("pre_rst_sf", sf(), 8'b11111_000);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_sf", sf(), 8'h00);
        chk("mid_rst_fw", fw(), 8'h00);
        chk("mid_rst_busy", busy(), 8'h00);
        tick();
        clr();
        rst_i = 1'b0;
        #1;
        chk("post_rst_busy", busy(), 8'h00);
        chk("post_rst_sf", sf(), 8'h00);
        tick();
        hz.icache_miss_i = 1'b1;
        #1;
        chk("post_rst_idle", sf(), 8'b10000_100);
        tick();
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that drives the stall/flush inputs of every stage register, including the execute-stage register, and the forwarding selects.
- Resolves RAW hazards through forwarding. Inserts load-use and branch-compare bubbles.
- Sequences cache-miss waits through a handshake FSM and holds the pipe during a multi-cycle mult/div.
- Sits beside the datapath and consumes the decoded register fields and control bits from the D, E, M and W stages.

Parameters:
MD_LATENCY, 32, total cycles a mult/div occupies E (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
rs_d_i, rt_d_i  in  5 each  source regs in D
branch_d_i  in  1  branch/jr compare in D needs operands
pc_src_d_i  in  1  control-flow redirect taken in D
rs_e_i, rt_e_i  in  5 each  source regs in E
write_reg_e_i  in  5  dest reg in E
reg_write_e_i, mem_to_reg_e_i  in  1 each  E writes reg / E is load
write_reg_m_i  in  5  dest reg in M
reg_write_m_i, mem_to_reg_m_i  in  1 each  M control
write_reg_w_i  in  5  dest reg in W
reg_write_w_i  in  1  W writes reg
md_start_e_i  in  1  mult/div valid in E
icache_miss_i, icache_ready_i  in  1 each  I-side miss / refill done
dcache_miss_i, dcache_ready_i  in  1 each  D-side miss / refill done
stall_f_o, stall_d_o, stall_e_o, stall_m_o, stall_w_o  out  1 each  hold stage register
flush_d_o, flush_e_o, flush_m_o  out  1 each  bubble stage register
forward_a_d_o, forward_b_d_o  out  1 each  M-result to D compare
forward_a_e_o, forward_b_e_o  out  2 each  E operand select: 00 reg file, 01 W result, 10 M result
md_busy_o  out  1  mult/div in progress

Behaviour:
- Reset: FSM to IDLE and md_cnt to 0 asynchronously. While rst_i is high, or in IDLE with no hazard, all stall/flush/forward outputs are 0. A reset mid-miss or mid-mult/div abandons it.
- Forwarding (combinational):
  - forward_a_e_o = 10 if rs_e_i != 0 && reg_write_m_i && write_reg_m_i == rs_e_i.
  - Otherwise 01 if rs_e_i != 0 && reg_write_w_i && write_reg_w_i == rs_e_i.
  - Otherwise 00. M beats W. Same rule for forward_b_e_o with rt_e_i.
  - forward_a_d_o = rs_d_i != 0 && reg_write_m_i && write_reg_m_i == rs_d_i. Same for b with rt_d_i.
- lw_stall = mem_to_reg_e_i && (rt_e_i == rs_d_i || rt_e_i == rt_d_i).
- br_stall = branch_d_i && one of:
  - reg_write_e_i && write_reg_e_i in {rs_d_i, rt_d_i}, or
  - mem_to_reg_m_i && write_reg_m_i in {rs_d_i, rt_d_i}.
  - Register 0 never matches.
- Cache FSM states: IDLE, D_WAIT, I_WAIT.
  - IDLE: to D_WAIT if dcache_miss_i (D has priority as the older instruction); else to I_WAIT if icache_miss_i.
  - D_WAIT: to IDLE when dcache_ready_i. Next cycle, a still-asserted icache_miss_i enters I_WAIT.
  - I_WAIT: to I_WAIT→D_WAIT is not allowed. Exits to IDLE on icache_ready_i.
  - A ready arriving in the same cycle the miss is detected does not skip the state; minimum wait is 1 cycle.
- Mult/div counter md_cnt:
  - In IDLE or I_WAIT, md_start_e_i with md_cnt == 0 loads MD_LATENCY-1.
  - Decrements each cycle unless in D_WAIT (frozen).
  - md_busy_o = (md_cnt != 0) || (md_start_e_i && md_cnt == 0).
- Stall/flush priority, highest first:
  1. D_WAIT, or (IDLE && dcache_miss_i): stall all five; no flushes.
  2. md_busy_o: stall_f, stall_d, stall_e; flush_m_o = 1.
  3. lw_stall || br_stall: stall_f, stall_d; flush_e_o = 1.
  4. I_WAIT, or (IDLE && icache_miss_i): stall_f; flush_d_o = 1.
  5. pc_src_d_i with no stall active: flush_d_o = 1.
- flush_X_o is never asserted together with stall_X_o. A stalled stage is never flushed.

Test Plan:
- Forward: M writes r5, W writes r5, rs_e = 5 -> forward_a_e_o = 10. M reg_write = 0 -> 01. rs_e = 0 -> 00.
- Load-use: lw into r3 in E, D uses rt = 3 -> stall_f = stall_d = flush_e = 1 for exactly 1 cycle. Then forward_b_e_o = 10.
- Branch in D on r4 with ALU writing r4 in E -> 1 cycle stall + flush_e. Next cycle forward_a_d_o = 1.
- D-miss with simultaneous I-miss, dcache_ready after 5 cycles -> all stalls 5 cycles, then I_WAIT until icache_ready. Only stall_f and flush_d during I_WAIT.
- MD_LATENCY = 4, md_start -> md_busy_o 4 cycles with stall_e and flush_m. A D-miss of 3 cycles mid-op extends busy to 7 cycles.
- Assert rst_i in D_WAIT with md_cnt = 2 -> all outputs 0 immediately. After release: IDLE, md_busy_o = 0.
